fft2d_frame_ctrl: RTL and testbench

Frame sequencer for the 8x8 two-dimensional FFT core. It collects a 64-sample complex frame from a one-sample-per-cycle valid/ready stream and holds it stable on the core's parallel inputs. It then waits the core's fixed latency, captures all 64 core outputs, and streams them out row-major with valid/ready. It sits between the upstream sample source and the parallel FFT core, and replaces hand-driven stimulus on the core's 128 input ports.

---
 rtl/fft2d_pkg.sv | 28 ++
 rtl/fft2d_unload_buf.sv | 40 ++++
 rtl/fft2d_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_fft2d_frame_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft2d_pkg.sv
// ----------------------------------------------------------------------------
// fft2d_pkg : shared constants, state encoding and slot helper for the 8x8 FFT
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fft2d_pkg;

  localparam int N         = 8;
  localparam int FRAME     = 64;
  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  // Rows and columns are 1-based; slots are row-major from 0.
  function automatic logic [5:0] slot(input int unsigned row, input int unsigned col);
    return 6'((row - 1) * N + (col - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft2d_unload_buf.sv
// ----------------------------------------------------------------------------
// fft2d_unload_buf : 64-slot capture register file with indexed read mux
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fft2d_unload_buf
  import fft2d_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_en_i,
  input  logic [FRAME*OUT_W-1:0] cap_r_i,
  input  logic [FRAME*OUT_W-1:0] cap_i_i,
  input  logic [5:0]             rd_idx_i,
  output logic [OUT_W-1:0]       rd_r_o,
  output logic [OUT_W-1:0]       rd_i_o
);

  logic [FRAME*OUT_W-1:0] cap_r_q;
  logic [FRAME*OUT_W-1:0] cap_i_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r_q <= '0;
      cap_i_q <= '0;
    end else if (cap_en_i) begin
      cap_r_q <= cap_r_i;
      cap_i_q <= cap_i_i;
    end
  end

  assign rd_r_o = cap_r_q[rd_idx_i*OUT_W +: OUT_W];
  assign rd_i_o = cap_i_q[rd_idx_i*OUT_W +: OUT_W];

endmodule

`default_nettype wire

// File: rtl/fft2d_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fft2d_frame_ctrl : loads a 64-sample frame, waits the core latency, unloads
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fft2d_frame_ctrl
  import fft2d_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int CORE_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_r,
  input  logic [IN_W-1:0]        in_i,
  output logic [FRAME*IN_W-1:0]  core_in_r,
  output logic [FRAME*IN_W-1:0]  core_in_i,
  input  logic [FRAME*OUT_W-1:0] core_out_r,
  input  logic [FRAME*OUT_W-1:0] core_out_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_r,
  output logic [OUT_W-1:0]       out_i,
  output logic                   out_last,
  output logic                   busy,
  output logic [7:0]             frame_cnt
);

  localparam int LAT_W = $clog2(CORE_LAT + 1);

  if (CORE_LAT < 1) begin : g_bad_core_lat
    $error("fft2d_frame_ctrl: CORE_LAT must be at least 1");
  end

  state_e             state_q, state_d;
  logic [5:0]         ld_idx_q, ld_idx_d;
  logic [5:0]         ul_idx_q, ul_idx_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [FRAME*IN_W-1:0] core_r_q, core_i_q;
  logic               in_fire, out_fire, cap_en;

  // Handshake outputs decode from registers only.
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);
  assign out_last  = out_valid && (ul_idx_q == 6'd63);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_UNLOAD);
  assign frame_cnt = frame_cnt_q;
  assign core_in_r = core_r_q;
  assign core_in_i = core_i_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    ld_idx_d    = ld_idx_q;
    ul_idx_d    = ul_idx_q;
    lat_cnt_d   = lat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    cap_en      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (in_fire) begin
          ld_idx_d = ld_idx_q + 6'd1;
          if (ld_idx_q == 6'd63) begin
            lat_cnt_d = LAT_W'(CORE_LAT);
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          cap_en   = 1'b1;
          ul_idx_d = 6'd0;
          state_d  = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (out_fire) begin
          ul_idx_d = ul_idx_q + 6'd1;
          if (ul_idx_q == 6'd63) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_idx_q    <= '0;
      ul_idx_q    <= '0;
      lat_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      ul_idx_q    <= ul_idx_d;
      lat_cnt_q   <= lat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The core sees each sample from its accept edge; only LOAD can write here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_r_q <= '0;
      core_i_q <= '0;
    end else if (in_fire) begin
      core_r_q[ld_idx_q*IN_W +: IN_W] <= in_r;
      core_i_q[ld_idx_q*IN_W +: IN_W] <= in_i;
    end
  end

  fft2d_unload_buf #(
    .OUT_W (OUT_W)
  ) u_unload_buf (
    .clk      (clk),
    .rst      (rst),
    .cap_en_i (cap_en),
    .cap_r_i  (core_out_r),
    .cap_i_i  (core_out_i),
    .rd_idx_i (ul_idx_q),
    .rd_r_o   (out_r),
    .rd_i_o   (out_i)
  );

endmodule

`default_nettype wire

// File: tb/tb_fft2d_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft2d_frame_ctrl : scoreboard bench with identity and DFT core stubs
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fft2d_frame_ctrl;
  import fft2d_pkg::*;

  localparam int IW  = 16;
  localparam int OW  = 24;
  localparam int LAT = 4;
  localparam int SD  = LAT - 1;
  localparam int K_ID = 0, K_IMP = 1, K_DC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [IW-1:0]     in_r, in_i;
  logic [64*IW-1:0]  core_in_r, core_in_i;
  logic [64*OW-1:0]  core_out_r, core_out_i;
  logic              out_valid, out_ready, out_last, busy;
  logic [OW-1:0]     out_r, out_i;
  logic [7:0]        frame_cnt;

  always #5 clk = ~clk;

  fft2d_frame_ctrl #(.IN_W(IW), .OUT_W(OW), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .core_in_r(core_in_r), .core_in_i(core_in_i),
    .core_out_r(core_out_r), .core_out_i(core_out_i), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_i(out_i), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // Core stub: the capture edge itself is the last latency cycle, so the
  // register pipeline is one stage shorter than the core latency.
  logic             dft_mode = 1'b0;
  logic [64*OW-1:0] pr [SD];
  logic [64*OW-1:0] pi [SD];

  function automatic logic [64*OW-1:0] ext(input logic [64*IW-1:0] x);
    logic [64*OW-1:0] y;
    for (int k = 0; k < 64; k++)
      y[k*OW +: OW] = {{(OW-IW){x[k*IW+IW-1]}}, x[k*IW +: IW]};
    return y;
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [2*64*OW-1:0] dft(input logic [64*IW-1:0] xr, input logic [64*IW-1:0] xi);
    logic [64*OW-1:0] yr, yi;
    real ar, ai, ang, sr, si;
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        ar = 0.0; ai = 0.0;
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            sr  = $itor($signed(xr[(8*r+c)*IW +: IW]));
            si  = $itor($signed(xi[(8*r+c)*IW +: IW]));
            ang = -2.0 * 3.14159265358979 * $itor((u*r + v*c) % 8) / 8.0;
            ar  = ar + sr*$cos(ang) - si*$sin(ang);
            ai  = ai + sr*$sin(ang) + si*$cos(ang);
          end
        end
        yr[(8*u+v)*OW +: OW] = OW'(rnd(ar));
        yi[(8*u+v)*OW +: OW] = OW'(rnd(ai));
      end
    end
    return {yr, yi};
  endfunction

  always @(posedge clk) begin
    if (dft_mode) {pr[0], pi[0]} <= dft(core_in_r, core_in_i);
    else begin
      pr[0] <= ext(core_in_r);
      pi[0] <= ext(core_in_i);
    end
    for (int j = 1; j < SD; j++) begin
      pr[j] <= pr[j-1];
      pi[j] <= pi[j-1];
    end
  end
  assign core_out_r = pr[SD-1];
  assign core_out_i = pi[SD-1];

  // Scoreboard
  typedef struct { logic [OW-1:0] r; logic [OW-1:0] i; logic last; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int ready_pct = 100;
  logic [IW-1:0] fr [64];
  logic [IW-1:0] fi [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: identity stub returns the sign-extended sample; a 2-D DFT of an
  // impulse is flat, and of a constant frame is 64x the constant at bin 0.
  task automatic push_frame(input int kind);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      case (kind)
        K_ID: begin
          e.r = OW'($signed(fr[k]));
          e.i = OW'($signed(fi[k]));
        end
        K_IMP: begin
          e.r = OW'(1);
          e.i = '0;
        end
        default: begin
          e.r = (k == 0) ? OW'(64) : '0;
          e.i = (k == 0) ? OW'(64) : '0;
        end
      endcase
      e.last = (k == 63);
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input int vpct, input int stop_after);
    int k = 0, guard = 0;
    logic fire;
    while (k < 64 && k != stop_after && guard < 5000) begin
      in_r = fr[k]; in_i = fi[k];
      in_valid = ($urandom_range(99) < vpct);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 5000) chk("load_timeout", 64'(k), 64'd64);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 64; k++) begin
      fr[k] = IW'((k/8 + 1) + (k%8 + 1));
      fi[k] = fr[k];
    end
  endtask

  task automatic fill_random(input logic [IW-1:0] orv);
    for (int k = 0; k < 64; k++) begin
      fr[k] = IW'($urandom) | orv;
      fi[k] = IW'($urandom) | orv;
    end
  endtask

  // Downstream ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: pops and compares on every output transfer, checks holds
  initial begin
    logic hv, hl;
    logic [OW-1:0] hr, hi;
    exp_t e;
    hv = 1'b0; hl = 1'b0; hr = '0; hi = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) hv = 1'b0;
      else begin
        if (busy) chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (hv) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_r", 64'(out_r), 64'(hr));
          chk("hold_i", 64'(out_i), 64'(hi));
          chk("hold_last", 64'(out_last), 64'(hl));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: unexpected output r=%0h i=%0h", out_r, out_i);
          end else begin
            e = q.pop_front();
            chk("out_r", 64'(out_r), 64'(e.r));
            chk("out_i", 64'(out_i), 64'(e.i));
            chk("out_last", 64'(out_last), 64'(e.last));
          end
        end
        hv = out_valid && !out_ready;
        hr = out_r; hi = out_i; hl = out_last;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0;
    do_reset();
    chk("rst_core_in", 64'(core_in_r[0 +: IW]), 64'd0);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("load_in_ready", 64'(in_ready), 64'd1);
    chk("load_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Ramp frame through identity core
    ready_pct = 100;
    fill_ramp(); push_frame(K_ID); send_frame(100, -1);
    chk("core_in_s0", 64'(core_in_r[slot(1,1)*IW +: IW]), 64'd2);
    chk("core_in_s63", 64'(core_in_i[slot(8,8)*IW +: IW]), 64'd16);
    chk("run_busy", 64'(busy), 64'd1);
    n = 0;
    while (n < 20) begin
      n++;
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("out_valid_lat", 64'(n), 64'(LAT));
    drain();
    chk("frame_cnt_1", 64'(frame_cnt), 64'd1);

    // Backpressure on a negative frame
    ready_pct = 30;
    fill_random(16'h8000); fr[0] = 16'hFFFF; fi[0] = 16'h8000;
    push_frame(K_ID); send_frame(50, -1); drain();
    chk("frame_cnt_2", 64'(frame_cnt), 64'd2);

    // DFT core: impulse and DC frames
    ready_pct = 100;
    dft_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin fr[k] = '0; fi[k] = '0; end
    fr[0] = 16'd1;
    push_frame(K_IMP); send_frame(100, -1); drain();
    for (int k = 0; k < 64; k++) begin fr[k] = 16'd1; fi[k] = 16'd1; end
    push_frame(K_DC); send_frame(100, -1); drain();
    dft_mode = 1'b0;
    chk("frame_cnt_4", 64'(frame_cnt), 64'd4);

    // Reset after 30 accepts, then a clean frame
    fill_random('0); push_frame(K_ID); send_frame(100, 30);
    do_reset();
    fill_random('0); push_frame(K_ID); send_frame(100, -1); drain();
    chk("frame_cnt_after_rst1", 64'(frame_cnt), 64'd1);

    // Reset during unload at ul_idx=10
    fill_random('0); push_frame(K_ID); send_frame(100, -1);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("unload_reached", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    fill_random('0); push_frame(K_ID); send_frame(100, -1); drain();
    chk("frame_cnt_after_rst2", 64'(frame_cnt), 64'd1);

    // 256 back-to-back frames wrap the frame counter
    do_reset();
    for (int f = 0; f < 256; f++) begin
      fill_random('0); push_frame(K_ID); send_frame(100, -1);
    end
    drain();
    chk("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
